// File: rtl/cronometro_pkg.sv
// Shared definitions for the mm:ss stopwatch: FSM encoding, digit limits, load sanitising.
// Latency: n/a (types, constants and a pure function only).
// Backpressure: n/a.
package cronometro_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // Largest value of a units digit (mod 10) and of a tens digit (mod 6).
  localparam logic [3:0]  UNIT_MAX = 4'd9;
  localparam logic [3:0]  TENS_MAX = 4'd5;

  // Last count before rollover, laid out as {min_t, min_u, sec_t, sec_u}.
  localparam logic [15:0] TERMINAL = {TENS_MAX, UNIT_MAX, TENS_MAX, UNIT_MAX};

  // A preset digit above its limit is not a legal BCD time digit; store 0 instead.
  function automatic logic [3:0] clip_digit(input logic [3:0] d, input logic [3:0] max);
    return (d > max) ? 4'd0 : d;
  endfunction

endpackage

// File: rtl/contador_up_bcd.sv
// One BCD digit of the stopwatch cascade: counts 0..MAX, clears, or loads a sanitised preset.
// Latency: q updates at the clock edge where ci/load/clr is high; co is combinational.
// Backpressure: none; ci is an enable, co = ci & (q == MAX) feeds the next digit.
module contador_up_bcd
  import cronometro_pkg::*;
#(
  parameter logic [3:0] MAX = UNIT_MAX
) (
  input  logic       clk,
  input  logic       clrn,
  input  logic       clr,
  input  logic       load,
  input  logic [3:0] ld_val,
  input  logic       ci,
  output logic [3:0] q,
  output logic       co
);

  // Digit register: clear beats load beats count; wraps MAX -> 0 when carried into.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      q <= 4'd0;
    end else if (clr) begin
      q <= 4'd0;
    end else if (load) begin
      q <= clip_digit(ld_val, MAX);
    end else if (ci) begin
      q <= (q == MAX) ? 4'd0 : q + 4'd1;
    end
  end

  assign co = ci & (q == MAX);

endmodule

// File: rtl/cronometro_mmss.sv
// mm:ss BCD stopwatch with start/stop/clear/preset control and optional rollover at 59:59.
// Latency: a tick in RUN updates the digits at that same edge; tc/zero are combinational.
// Backpressure: none; controls are sampled every cycle with priority clr > loadn > stop > start > tick.
module cronometro_mmss
  import cronometro_pkg::*;
#(
  parameter bit WRAP = 1'b1
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        tick,
  input  logic        start,
  input  logic        stop,
  input  logic        clr,
  input  logic        loadn,
  input  logic [15:0] data,
  output logic [3:0]  sec_u,
  output logic [3:0]  sec_t,
  output logic [3:0]  min_u,
  output logic [3:0]  min_t,
  output logic        running,
  output logic        zero,
  output logic        tc
);

  state_t state, state_nxt;

  logic at_term;   // digits currently read 59:59
  logic load;      // preset accepted this cycle
  logic adv;       // a tick that is allowed to count this cycle
  logic hold;      // no-rollover variant parked at 59:59
  logic ci_su;     // carry-in to the seconds-units digit
  logic co_su, co_st, co_mu, co_mt;
  logic term_evt;  // the step that would leave 59:59

  assign at_term = ({min_t, min_u, sec_t, sec_u} == TERMINAL);
  assign running = (state == RUN);
  assign zero    = ({min_t, min_u, sec_t, sec_u} == 16'h0000);
  assign tc      = running & tick & at_term;

  // Preset is refused while running; clr overrides it anyway.
  assign load  = !loadn && (state != RUN) && !clr;
  // stop and clr both outrank tick, so a coincident tick never counts.
  assign adv   = running & tick & !stop & !clr;
  assign hold  = !WRAP & at_term;
  assign ci_su = adv & !hold;

  // With rollover the top digit's carry-out marks the terminal step; without it
  // the cascade is frozen at 59:59, so the terminal step is decoded directly.
  assign term_evt = WRAP ? co_mt : (adv & at_term);

  // State register.
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state decode in control priority order.
  always_comb begin
    state_nxt = state;
    if (clr) begin
      state_nxt = IDLE;
    end else if (!loadn && (state != RUN)) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE, PAUSE: if (start && !stop) state_nxt = RUN;
        RUN: begin
          if (stop) begin
            state_nxt = PAUSE;
          end else if (term_evt && !WRAP) begin
            state_nxt = DONE;
          end
        end
        DONE:    state_nxt = DONE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  contador_up_bcd #(.MAX(UNIT_MAX)) u_sec_u (
    .clk(clk), .clrn(clrn), .clr(clr), .load(load), .ld_val(data[3:0]),
    .ci(ci_su), .q(sec_u), .co(co_su)
  );

  contador_up_bcd #(.MAX(TENS_MAX)) u_sec_t (
    .clk(clk), .clrn(clrn), .clr(clr), .load(load), .ld_val(data[7:4]),
    .ci(co_su), .q(sec_t), .co(co_st)
  );

  contador_up_bcd #(.MAX(UNIT_MAX)) u_min_u (
    .clk(clk), .clrn(clrn), .clr(clr), .load(load), .ld_val(data[11:8]),
    .ci(co_st), .q(min_u), .co(co_mu)
  );

  contador_up_bcd #(.MAX(TENS_MAX)) u_min_t (
    .clk(clk), .clrn(clrn), .clr(clr), .load(load), .ld_val(data[15:12]),
    .ci(co_mu), .q(min_t), .co(co_mt)
  );

endmodule

// File: tb/tb_cronometro_mmss.sv
// Self-checking bench for cronometro_mmss: one rollover and one hold-at-59:59 instance share stimulus.
// Latency: each vector is driven at negedge and checked 1 time unit after the following posedge.
// Backpressure: n/a.
module tb_cronometro_mmss;

  logic        clk = 1'b0;
  logic        clrn, tick, start, stop, clr, loadn;
  logic [15:0] data;

  logic [3:0]  w_su, w_st, w_mu, w_mt, h_su, h_st, h_mu, h_mt;
  logic        w_run, w_zero, w_tc, h_run, h_zero, h_tc;

  always #5 clk = ~clk;

  cronometro_mmss #(.WRAP(1'b1)) u_wrap (
    .clk(clk), .clrn(clrn), .tick(tick), .start(start), .stop(stop), .clr(clr),
    .loadn(loadn), .data(data), .sec_u(w_su), .sec_t(w_st), .min_u(w_mu), .min_t(w_mt),
    .running(w_run), .zero(w_zero), .tc(w_tc)
  );

  cronometro_mmss #(.WRAP(1'b0)) u_hold (
    .clk(clk), .clrn(clrn), .tick(tick), .start(start), .stop(stop), .clr(clr),
    .loadn(loadn), .data(data), .sec_u(h_su), .sec_t(h_st), .min_u(h_mu), .min_t(h_mt),
    .running(h_run), .zero(h_zero), .tc(h_tc)
  );

  typedef struct {
    logic        start, stop, clr, loadn, tick;
    logic [15:0] data;
    logic [15:0] cnt;   // expected count, rollover instance
    logic        run;
    logic        tc;    // expected tc while the vector is applied (both instances)
    logic [15:0] hcnt;  // expected count, hold instance
    logic        hrun;
  } vec_t;

  typedef struct {
    int          id;
    logic [15:0] cnt;
    logic        run;
    logic        tc;
    logic [15:0] hcnt;
    logic        hrun;
  } exp_t;

  vec_t tbl[$];
  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  logic tc_w, tc_h;

  task automatic chk(input string name, input int id, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s step %0d: got %h expected %h", name, id, act, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int s);
    int m, r;
    m = s / 60;
    r = s % 60;
    return {4'(m / 10), 4'(m % 10), 4'(r / 10), 4'(r % 10)};
  endfunction

  task automatic add(input logic st, input logic sp, input logic cl, input logic ln, input logic tk,
                     input logic [15:0] d, input logic [15:0] c, input logic r, input logic t,
                     input logic [15:0] hc, input logic hr);
    vec_t v;
    v.start = st; v.stop = sp; v.clr = cl; v.loadn = ln; v.tick = tk; v.data = d;
    v.cnt = c; v.run = r; v.tc = t; v.hcnt = hc; v.hrun = hr;
    tbl.push_back(v);
  endtask

  task automatic apply(input vec_t v, input int id);
    exp_t e;
    e.id = id; e.cnt = v.cnt; e.run = v.run; e.tc = v.tc; e.hcnt = v.hcnt; e.hrun = v.hrun;
    sb.push_back(e);
    @(negedge clk);
    start = v.start; stop = v.stop; clr = v.clr; loadn = v.loadn; tick = v.tick; data = v.data;
    #1;
    tc_w = w_tc;
    tc_h = h_tc;
    @(posedge clk);
    #1;
    e = sb.pop_front();
    chk("count",        e.id, {w_mt, w_mu, w_st, w_su}, e.cnt);
    chk("running",      e.id, 16'(w_run),  16'(e.run));
    chk("zero",         e.id, 16'(w_zero), 16'(e.cnt == 16'h0000));
    chk("tc",           e.id, 16'(tc_w),   16'(e.tc));
    chk("hold_count",   e.id, {h_mt, h_mu, h_st, h_su}, e.hcnt);
    chk("hold_running", e.id, 16'(h_run),  16'(e.hrun));
    chk("hold_tc",      e.id, 16'(tc_h),   16'(e.tc));
  endtask

  task automatic idle_inputs();
    start = 1'b0; stop = 1'b0; clr = 1'b0; loadn = 1'b1; tick = 1'b0; data = 16'h0000;
  endtask

  initial begin
    vec_t v;
    idle_inputs();
    clrn = 1'b0;
    tick = 1'b1;  // tc must stay low in reset even with tick high

    // Reset state, held asynchronously before any clock edge
    #3;
    chk("rst_count",   -1, {w_mt, w_mu, w_st, w_su}, 16'h0000);
    chk("rst_running", -1, 16'(w_run),  16'h0000);
    chk("rst_zero",    -1, 16'(w_zero), 16'h0001);
    chk("rst_tc",      -1, 16'(w_tc),   16'h0000);
    @(negedge clk);
    tick = 1'b0;
    clrn = 1'b1;

    //   st sp cl ln tk data      cnt      run tc  hcnt     hrun
    add(0, 0, 0, 1, 1, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0);  // tick in IDLE ignored
    add(1, 0, 0, 1, 1, 16'h0000, 16'h0000, 1, 0, 16'h0000, 1);  // tick with accepted start not counted
    for (int i = 1; i <= 60; i++)
      add(0, 0, 0, 1, 1, 16'h0000, to_bcd(i), 1, 0, to_bcd(i), 1);  // 00:01 .. 01:00
    add(0, 1, 0, 1, 0, 16'h0000, 16'h0100, 0, 0, 16'h0100, 0);  // stop -> PAUSE
    add(0, 0, 0, 1, 1, 16'h0000, 16'h0100, 0, 0, 16'h0100, 0);  // tick in PAUSE ignored
    add(1, 1, 0, 1, 0, 16'h0000, 16'h0100, 0, 0, 16'h0100, 0);  // start+stop in PAUSE: unchanged
    add(1, 0, 0, 1, 0, 16'h0000, 16'h0100, 1, 0, 16'h0100, 1);  // resume
    add(0, 0, 0, 0, 0, 16'h2222, 16'h0100, 1, 0, 16'h0100, 1);  // loadn ignored in RUN
    add(0, 0, 0, 0, 1, 16'h2222, 16'h0101, 1, 0, 16'h0101, 1);  // loadn in RUN, tick still counts
    add(0, 1, 0, 1, 0, 16'h0000, 16'h0101, 0, 0, 16'h0101, 0);  // stop
    add(0, 0, 0, 0, 0, 16'h7A34, 16'h0034, 0, 0, 16'h0034, 0);  // invalid tens/units zeroed
    add(0, 0, 0, 0, 0, 16'h0321, 16'h0321, 0, 0, 16'h0321, 0);  // load 03:21
    add(1, 0, 0, 1, 0, 16'h0000, 16'h0321, 1, 0, 16'h0321, 1);  // start
    add(1, 1, 0, 1, 1, 16'h0000, 16'h0321, 0, 0, 16'h0321, 0);  // start+stop+tick in RUN -> PAUSE
    add(1, 0, 0, 1, 0, 16'h0000, 16'h0321, 1, 0, 16'h0321, 1);  // resume from PAUSE
    add(0, 1, 0, 1, 0, 16'h0000, 16'h0321, 0, 0, 16'h0321, 0);  // stop
    add(0, 0, 0, 0, 0, 16'h5958, 16'h5958, 0, 0, 16'h5958, 0);  // load 59:58
    add(1, 0, 0, 1, 0, 16'h0000, 16'h5958, 1, 0, 16'h5958, 1);  // start
    add(0, 0, 0, 1, 1, 16'h0000, 16'h5959, 1, 0, 16'h5959, 1);  // 59:59, tc low (was 59:58)
    add(0, 0, 0, 1, 1, 16'h0000, 16'h0000, 1, 1, 16'h5959, 0);  // terminal: wrap vs hold/DONE
    add(1, 0, 0, 1, 0, 16'h0000, 16'h0000, 1, 0, 16'h5959, 0);  // start ignored in RUN and DONE
    add(0, 0, 0, 1, 1, 16'h0000, 16'h0001, 1, 0, 16'h5959, 0);  // wrapped one keeps counting
    add(0, 0, 1, 0, 0, 16'h1111, 16'h0000, 0, 0, 16'h0000, 0);  // clr beats loadn (DONE on hold)
    add(1, 0, 0, 1, 0, 16'h0000, 16'h0000, 1, 0, 16'h0000, 1);  // start, no tick: unchanged
    add(0, 0, 0, 1, 1, 16'h0000, 16'h0001, 1, 0, 16'h0001, 1);  // next tick counts
    add(0, 0, 1, 1, 1, 16'h0000, 16'h0000, 0, 0, 16'h0000, 0);  // clr in RUN beats tick
    add(0, 0, 0, 0, 0, 16'h1233, 16'h1233, 0, 0, 16'h1233, 0);  // set up 12:34 for reset abort
    add(1, 0, 0, 1, 0, 16'h0000, 16'h1233, 1, 0, 16'h1233, 1);
    add(0, 0, 0, 1, 1, 16'h0000, 16'h1234, 1, 0, 16'h1234, 1);

    for (int i = 0; i < tbl.size(); i++) begin
      v = tbl[i];
      apply(v, i);
    end

    // Asynchronous reset mid-RUN at 12:34: takes effect between clock edges
    @(negedge clk);
    idle_inputs();
    tick = 1'b1;
    #1;
    clrn = 1'b0;
    #1;
    chk("arst_count",   -2, {w_mt, w_mu, w_st, w_su}, 16'h0000);
    chk("arst_running", -2, 16'(w_run),  16'h0000);
    chk("arst_zero",    -2, 16'(w_zero), 16'h0001);
    chk("arst_tc",      -2, 16'(w_tc),   16'h0000);
    @(posedge clk);
    #1;
    chk("arst_hold_count", -3, {w_mt, w_mu, w_st, w_su}, 16'h0000);
    @(negedge clk);
    clrn = 1'b1;
    // Released into IDLE: a tick must not count
    @(posedge clk);
    #1;
    chk("post_rst_count",   -4, {w_mt, w_mu, w_st, w_su}, 16'h0000);
    chk("post_rst_running", -4, 16'(w_run), 16'h0000);
    @(negedge clk);
    idle_inputs();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Global watchdog so the run always ends
  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, got timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/cronometro_mmss.md
CRONOMETRO_MMSS -- requirements
Module: cronometro_mmss

Interface
REQ-001 Parameter WRAP, default 1, SHALL select behaviour at 59:59: 1 = roll over to 00:00, 0 = hold and stop.
REQ-002 clk  input  1  SHALL be the clock; all state changes occur on the rising edge.
REQ-003 clrn  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 tick  input  1  SHALL be a one-clk-wide count enable pulse, nominally 1 Hz.
REQ-005 start  input  1  SHALL be a synchronous start/resume request.
REQ-006 stop  input  1  SHALL be a synchronous pause request.
REQ-007 clr  input  1  SHALL be a synchronous clear to 00:00.
REQ-008 loadn  input  1  SHALL be a synchronous, active-low preset strobe.
REQ-009 data  input  16  SHALL be the preset value in BCD, {min_t, min_u, sec_t, sec_u}.
REQ-010 sec_u, sec_t, min_u, min_t  output  4 each  SHALL be the registered BCD count digits.
REQ-011 running  output  1  SHALL be high only in state RUN.
REQ-012 zero  output  1  SHALL be high when the count is 00:00, combinational from the digit registers.
REQ-013 tc  output  1  SHALL equal running & tick & (count == 59:59).

Function
REQ-014 The count SHALL be an up-counting cascade: sec_u mod 10, sec_t mod 6, min_u mod 10, min_t mod 6; each digit SHALL advance only when all lower digits are at their maximum.
REQ-015 The FSM SHALL have exactly four states: IDLE, RUN, PAUSE, DONE.
REQ-016 In RUN with tick=1 the count SHALL advance by one second at that edge (zero-cycle latency from tick to the digit update).
REQ-017 The count SHALL hold in IDLE, PAUSE, DONE, and in RUN when tick=0.
REQ-018 At 59:59 in RUN with tick=1: if WRAP=1 the count SHALL become 00:00 and the state SHALL stay RUN; if WRAP=0 the count SHALL hold 59:59 and the state SHALL go to DONE.
REQ-019 State transitions on start SHALL be: IDLE->RUN, PAUSE->RUN; start SHALL be ignored in RUN and DONE.
REQ-020 State transition on stop SHALL be RUN->PAUSE; stop SHALL be ignored in other states.
REQ-021 When start and stop are both high, stop SHALL win; the resulting state SHALL be PAUSE from RUN and unchanged otherwise.
REQ-022 clr SHALL set the count to 00:00 and the state to IDLE from any state, with the highest synchronous priority (clr > loadn > stop > start > tick).
REQ-023 loadn=0 SHALL load data into the digits and force the state to IDLE when the state is IDLE, PAUSE or DONE; loadn SHALL be ignored in RUN.
REQ-024 An out-of-range loaded digit (unit digit >9, tens digit >5) SHALL be stored as 0; the other digits SHALL load normally.
REQ-025 A tick coincident with an accepted start SHALL NOT advance the count; counting SHALL begin on the next tick.

Reset
REQ-026 While clrn=0, the digits SHALL be 0 and the state IDLE, independent of clk, giving running=0, zero=1, tc=0.
REQ-027 Deassertion of clrn SHALL leave the block in IDLE; clrn asserted mid-count SHALL abort immediately with no further carry.

Structure
REQ-028 The state encoding and the digit limits (9, 5, and the 59:59 terminal value) SHALL reside in the shared package cronometro_pkg.
REQ-029 Each digit SHALL be an instance of the sub-module contador_up_bcd, with parameter MAX, inputs clk, clrn, clr, load, ld_val, ci and outputs q, co, where co = ci & (q == MAX).

Verification
REQ-030 Test: clrn pulse low mid-RUN at 12:34 -> digits 00:00 immediately, running=0, zero=1.
REQ-031 Test: start, then 10 ticks from 00:00 -> 00:10; then 50 more ticks -> 01:00, with sec_t carrying correctly 5->0.
REQ-032 Test: load 0x5958, start, 2 ticks with WRAP=1 -> tc=1 on the second tick, then 00:00 and running=1; same with WRAP=0 -> hold 59:59 and state DONE.
REQ-033 Test: load 0x7A34 -> stored 00:34 (both invalid digits zeroed); loadn=0 during RUN -> count unchanged.
REQ-034 Test: start, stop and tick in the same cycle during RUN at 03:21 -> state PAUSE, count stays 03:21.
REQ-035 Test: clr together with loadn=0 in DONE -> 00:00 and IDLE; a later start -> RUN, with the count unchanged until the next tick.
